// File: rtl/ucsbece154b_victim_ctrl.sv
// Miss-path controller: serialises one L1 miss through the victim cache and
// next-level memory, swaps the evicted line into the victim cache, keeps stats.
module ucsbece154b_victim_ctrl #(
    parameter int ADDR_WIDTH = 56,
    parameter int LINE_WIDTH = 128,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  evict_valid_i,
    input  logic [ADDR_WIDTH-1:0] evict_addr_i,
    input  logic [LINE_WIDTH-1:0] evict_data_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [LINE_WIDTH-1:0] resp_data_o,
    output logic                  resp_from_vc_o,
    output logic                  vc_en_o,
    output logic                  vc_flush_o,
    output logic [ADDR_WIDTH-1:0] vc_raddr_o,
    input  logic                  vc_hit_i,
    input  logic [LINE_WIDTH-1:0] vc_rdata_i,
    output logic                  vc_we_o,
    output logic [ADDR_WIDTH-1:0] vc_waddr_o,
    output logic [LINE_WIDTH-1:0] vc_wdata_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    input  logic [LINE_WIDTH-1:0] mem_resp_data_i,
    output logic [CNT_WIDTH-1:0]  hit_count_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o
);

    localparam int OFF_W = $clog2(LINE_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        EVICT,
        RESP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] evict_addr_q;
    logic                  evict_valid_q;
    logic [LINE_WIDTH-1:0] evict_data_q;
    logic [LINE_WIDTH-1:0] line_q;
    logic                  from_vc_q;
    logic                  abort_q;
    logic                  ready_q;
    logic                  mem_valid_q;
    logic                  we_q;
    logic                  resp_q;
    logic                  en_q;
    logic [CNT_WIDTH-1:0]  hit_q;
    logic [CNT_WIDTH-1:0]  miss_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // A flush landing in EVICT or RESP must suppress the write and the fill
    // in that same cycle, so the registered strobes are masked by flush_i.
    assign req_ready_o     = ready_q;
    assign resp_valid_o    = resp_q & ~flush_i;
    assign resp_data_o     = line_q;
    assign resp_from_vc_o  = from_vc_q;
    assign vc_en_o         = en_q;
    assign vc_flush_o      = flush_i;
    assign vc_raddr_o      = addr_q;
    assign vc_we_o         = we_q & ~flush_i;
    assign vc_waddr_o      = evict_addr_q;
    assign vc_wdata_o      = evict_data_q;
    assign mem_req_valid_o = mem_valid_q;
    assign mem_req_addr_o  = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign hit_count_o     = hit_q;
    assign miss_count_o    = miss_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            addr_q        <= '0;
            evict_addr_q  <= '0;
            evict_valid_q <= 1'b0;
            evict_data_q  <= '0;
            line_q        <= '0;
            from_vc_q     <= 1'b0;
            abort_q       <= 1'b0;
            ready_q       <= 1'b1;
            mem_valid_q   <= 1'b0;
            we_q          <= 1'b0;
            resp_q        <= 1'b0;
            en_q          <= 1'b0;
            hit_q         <= '0;
            miss_q        <= '0;
        end else begin
            en_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (!flush_i && req_valid_i) begin
                        addr_q        <= req_addr_i;
                        evict_valid_q <= evict_valid_i;
                        evict_addr_q  <= evict_addr_i;
                        evict_data_q  <= evict_data_i;
                        ready_q       <= 1'b0;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // The lookup result is counted even if a flush aborts it.
                    if (vc_hit_i) begin
                        line_q    <= vc_rdata_i;
                        from_vc_q <= 1'b1;
                        hit_q     <= sat_inc(hit_q);
                    end else begin
                        miss_q <= sat_inc(miss_q);
                    end
                    if (flush_i) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else if (vc_hit_i) begin
                        we_q  <= evict_valid_q;
                        state <= EVICT;
                    end else begin
                        mem_valid_q <= 1'b1;
                        state       <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (flush_i) abort_q <= 1'b1;
                    if (mem_req_ready_i) begin
                        mem_valid_q <= 1'b0;
                        state       <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (flush_i) abort_q <= 1'b1;
                    if (mem_resp_valid_i) begin
                        line_q    <= mem_resp_data_i;
                        from_vc_q <= 1'b0;
                        if (abort_q || flush_i) begin
                            abort_q <= 1'b0;
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            we_q  <= evict_valid_q;
                            state <= EVICT;
                        end
                    end
                end
                EVICT: begin
                    we_q <= 1'b0;
                    if (flush_i) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        resp_q <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (flush_i || resp_ready_i) begin
                        resp_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_valid_q <= 1'b0;
                    we_q        <= 1'b0;
                    resp_q      <= 1'b0;
                    ready_q     <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154b_victim_ctrl.sv
// Directed bench for the victim-cache miss-path controller.
module tb_ucsbece154b_victim_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [55:0]  req_addr_i;
    logic         evict_valid_i;
    logic [55:0]  evict_addr_i;
    logic [127:0] evict_data_i;
    logic         resp_valid_o;
    logic         resp_ready_i;
    logic [127:0] resp_data_o;
    logic         resp_from_vc_o;
    logic         vc_en_o;
    logic         vc_flush_o;
    logic [55:0]  vc_raddr_o;
    logic         vc_hit_i;
    logic [127:0] vc_rdata_i;
    logic         vc_we_o;
    logic [55:0]  vc_waddr_o;
    logic [127:0] vc_wdata_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [55:0]  mem_req_addr_o;
    logic         mem_resp_valid_i;
    logic [127:0] mem_resp_data_i;
    logic [31:0]  hit_count_o;
    logic [31:0]  miss_count_o;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] DA = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] DB = 128'hBBBB_0123_4567_89AB_CDEF_0011_2233_4455;
    localparam logic [127:0] DC = 128'hCCCC_FEDC_BA98_7654_3210_9988_7766_5544;
    localparam logic [127:0] DD = 128'hDDDD_1234_5678_9ABC_DEF0_1357_2468_ACE0;
    localparam logic [127:0] DE = 128'hEEEE_5A5A_A5A5_0F0F_F0F0_C3C3_3C3C_9669;

    ucsbece154b_victim_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .evict_valid_i(evict_valid_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
        .resp_from_vc_o(resp_from_vc_o), .vc_en_o(vc_en_o), .vc_flush_o(vc_flush_o),
        .vc_raddr_o(vc_raddr_o), .vc_hit_i(vc_hit_i), .vc_rdata_i(vc_rdata_i),
        .vc_we_o(vc_we_o), .vc_waddr_o(vc_waddr_o), .vc_wdata_o(vc_wdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_data_i(mem_resp_data_i), .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [55:0] a, input logic ev, input logic [55:0] ea,
                         input logic [127:0] ed);
        req_valid_i   = 1'b1;
        req_addr_i    = a;
        evict_valid_i = ev;
        evict_addr_i  = ea;
        evict_data_i  = ed;
        step();
        req_valid_i   = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0;
        evict_valid_i = 1'b0; evict_addr_i = '0; evict_data_i = '0;
        resp_ready_i = 1'b0; vc_hit_i = 1'b0; vc_rdata_i = '0;
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;

        // Reset state
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_req_ready", 128'(req_ready_o), 128'd1);
        chk("rst_vc_en", 128'(vc_en_o), 128'd0);
        chk("rst_resp_valid", 128'(resp_valid_o), 128'd0);
        chk("rst_mem_valid", 128'(mem_req_valid_o), 128'd0);
        chk("rst_vc_we", 128'(vc_we_o), 128'd0);
        chk("rst_hits", 128'(hit_count_o), 128'd0);
        chk("rst_misses", 128'(miss_count_o), 128'd0);
        chk("rst_resp_data", resp_data_o, 128'd0);
        step();
        step();
        chk("rst_hold_vc_en", 128'(vc_en_o), 128'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rel_vc_en_before_edge", 128'(vc_en_o), 128'd0);
        step();
        chk("rel_vc_en", 128'(vc_en_o), 128'd1);
        chk("rel_req_ready", 128'(req_ready_o), 128'd1);

        // Victim-cache hit
        issue(56'h1000, 1'b1, 56'h2000, DA);
        vc_hit_i = 1'b1; vc_rdata_i = DB;
        chk("hit_raddr", 128'(vc_raddr_o), 128'h1000);
        chk("hit_ready_low", 128'(req_ready_o), 128'd0);
        chk("hit_lookup_we", 128'(vc_we_o), 128'd0);
        step();
        vc_hit_i = 1'b0; vc_rdata_i = '0;
        chk("hit_we", 128'(vc_we_o), 128'd1);
        chk("hit_waddr", 128'(vc_waddr_o), 128'h2000);
        chk("hit_wdata", vc_wdata_o, DA);
        chk("hit_evict_no_resp", 128'(resp_valid_o), 128'd0);
        chk("hit_count", 128'(hit_count_o), 128'd1);
        chk("hit_no_mem", 128'(mem_req_valid_o), 128'd0);
        step();
        chk("hit_resp_valid", 128'(resp_valid_o), 128'd1);
        chk("hit_resp_data", resp_data_o, DB);
        chk("hit_from_vc", 128'(resp_from_vc_o), 128'd1);
        chk("hit_resp_we_off", 128'(vc_we_o), 128'd0);
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        chk("hit_done_ready", 128'(req_ready_o), 128'd1);
        chk("hit_done_resp", 128'(resp_valid_o), 128'd0);

        // Miss with memory backpressure and delayed response
        issue(56'h1040, 1'b1, 56'h3000, DD);
        vc_hit_i = 1'b0;
        step();
        chk("miss_count", 128'(miss_count_o), 128'd1);
        for (int i = 0; i < 3; i++) begin
            chk("miss_mem_valid_stall", 128'(mem_req_valid_o), 128'd1);
            chk("miss_mem_addr_stall", 128'(mem_req_addr_o), 128'h1040);
            step();
        end
        mem_req_ready_i = 1'b1;
        chk("miss_mem_valid_hs", 128'(mem_req_valid_o), 128'd1);
        step();
        mem_req_ready_i = 1'b0;
        chk("miss_mem_valid_drop", 128'(mem_req_valid_o), 128'd0);
        for (int i = 0; i < 4; i++) begin
            chk("miss_wait_no_resp", 128'(resp_valid_o), 128'd0);
            step();
        end
        mem_resp_valid_i = 1'b1; mem_resp_data_i = DC;
        step();
        mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
        chk("miss_we", 128'(vc_we_o), 128'd1);
        chk("miss_waddr", 128'(vc_waddr_o), 128'h3000);
        chk("miss_wdata", vc_wdata_o, DD);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("miss_hold_valid", 128'(resp_valid_o), 128'd1);
            chk("miss_hold_data", resp_data_o, DC);
            chk("miss_hold_from_vc", 128'(resp_from_vc_o), 128'd0);
            chk("miss_hold_ready", 128'(req_ready_o), 128'd0);
            step();
        end
        resp_ready_i = 1'b1;
        chk("miss_hs_ready", 128'(req_ready_o), 128'd0);
        step();
        resp_ready_i = 1'b0;
        chk("miss_done_ready", 128'(req_ready_o), 128'd1);
        chk("miss_done_resp", 128'(resp_valid_o), 128'd0);

        // Miss without an evicted line
        issue(56'h4000, 1'b0, 56'h5000, DA);
        step();
        mem_req_ready_i = 1'b1;
        chk("noev_mem_valid", 128'(mem_req_valid_o), 128'd1);
        step();
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b1; mem_resp_data_i = DE;
        step();
        mem_resp_valid_i = 1'b0;
        chk("noev_we", 128'(vc_we_o), 128'd0);
        step();
        chk("noev_resp_valid", 128'(resp_valid_o), 128'd1);
        chk("noev_resp_data", resp_data_o, DE);
        chk("noev_misses", 128'(miss_count_o), 128'd2);
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;

        // Flush while waiting on memory
        issue(56'h2238, 1'b1, 56'h6000, DB);
        step();
        chk("flush_mem_addr_aligned", 128'(mem_req_addr_o), 128'h2230);
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        flush_i = 1'b1;
        #1;
        chk("flush_vc_flush", 128'(vc_flush_o), 128'd1);
        step();
        flush_i = 1'b0;
        #1;
        chk("flush_vc_flush_off", 128'(vc_flush_o), 128'd0);
        chk("flush_still_busy", 128'(req_ready_o), 128'd0);
        mem_resp_valid_i = 1'b1; mem_resp_data_i = DC;
        step();
        mem_resp_valid_i = 1'b0;
        chk("flush_idle_ready", 128'(req_ready_o), 128'd1);
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_we", 128'(vc_we_o), 128'd0);
            chk("flush_no_resp", 128'(resp_valid_o), 128'd0);
            step();
        end
        chk("flush_misses", 128'(miss_count_o), 128'd3);
        chk("flush_hits", 128'(hit_count_o), 128'd1);

        // Asynchronous reset during MEM_REQ
        issue(56'h5000, 1'b1, 56'h7000, DA);
        step();
        chk("areset_mem_valid_pre", 128'(mem_req_valid_o), 128'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("areset_mem_valid", 128'(mem_req_valid_o), 128'd0);
        chk("areset_vc_en", 128'(vc_en_o), 128'd0);
        chk("areset_hits", 128'(hit_count_o), 128'd0);
        chk("areset_misses", 128'(miss_count_o), 128'd0);
        chk("areset_ready", 128'(req_ready_o), 128'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        mem_resp_valid_i = 1'b1; mem_resp_data_i = DE;
        step();
        mem_resp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("areset_no_resp", 128'(resp_valid_o), 128'd0);
            chk("areset_no_we", 128'(vc_we_o), 128'd0);
            step();
        end
        chk("areset_vc_en_back", 128'(vc_en_o), 128'd1);
        chk("areset_idle_ready", 128'(req_ready_o), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ucsbece154b_victim_ctrl.md
Name: ucsbece154b_victim_ctrl

Overview:
Miss-path controller that sequences one L1 miss at a time through the victim cache and next-level memory. It accepts an L1 miss request along with the line L1 is evicting, and looks the miss address up in the victim cache. On a victim-cache miss it fetches the line from memory, then writes the evicted line into the victim cache and returns the fill line to L1. It also owns victim-cache enable/flush sequencing and keeps hit/miss statistics.

Parameters:
ADDR_WIDTH, 56, byte address width (matches victim cache)
LINE_WIDTH, 128, cache line width in bits (matches victim cache)
CNT_WIDTH, 32, width of each statistics counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  flush request (one-cycle pulse or level)
req_valid_i  in  1  L1 miss request valid
req_ready_o  out  1  controller can accept a request
req_addr_i  in  ADDR_WIDTH  miss address
evict_valid_i  in  1  L1 is evicting a valid line with this request
evict_addr_i  in  ADDR_WIDTH  evicted line address
evict_data_i  in  LINE_WIDTH  evicted line data
resp_valid_o  out  1  fill line valid
resp_ready_i  in  1  L1 accepts fill
resp_data_o  out  LINE_WIDTH  fill line
resp_from_vc_o  out  1  fill came from victim cache
vc_en_o  out  1  victim cache enable
vc_flush_o  out  1  victim cache flush
vc_raddr_o  out  ADDR_WIDTH  victim cache read address
vc_hit_i  in  1  victim cache hit (combinational)
vc_rdata_i  in  LINE_WIDTH  victim cache read data (combinational)
vc_we_o  out  1  victim cache write enable
vc_waddr_o  out  ADDR_WIDTH  victim cache write address
vc_wdata_o  out  LINE_WIDTH  victim cache write data
mem_req_valid_o  out  1  memory read request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  ADDR_WIDTH  memory read address (line-aligned; offset bits zeroed)
mem_resp_valid_i  in  1  memory read data valid (one-cycle pulse, no backpressure)
mem_resp_data_i  in  LINE_WIDTH  memory read data
hit_count_o  out  CNT_WIDTH  victim cache hits
miss_count_o  out  CNT_WIDTH  victim cache misses

Behaviour:
- Clock is clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - State IDLE; all valid, we and ready outputs 0, except req_ready_o, which is 1 in IDLE.
  - vc_en_o 0 while rst_ni is low; 1 from the first clock edge after reset release.
  - Counters 0; data outputs 0.
- States: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, EVICT, RESP.
- IDLE:
  - req_ready_o=1.
  - A handshake (req_valid_i & req_ready_o) captures req_addr_i and the evict_* fields, then moves to LOOKUP.
  - req_ready_o is 0 in every other state.
- LOOKUP (1 cycle):
  - vc_raddr_o = captured address.
  - If vc_hit_i=1: latch vc_rdata_i, set from_vc=1, hit_count+1, go to EVICT.
  - If vc_hit_i=0: miss_count+1, go to MEM_REQ.
- MEM_REQ:
  - mem_req_valid_o=1 with mem_req_addr_o stable until mem_req_ready_i=1, then go to MEM_WAIT.
  - Valid is never withdrawn before the handshake.
- MEM_WAIT:
  - On mem_resp_valid_i, latch mem_resp_data_i, set from_vc=0, go to EVICT.
  - A response arriving in MEM_REQ is a protocol error (ignored).
- EVICT (1 cycle):
  - vc_we_o = captured evict_valid.
  - vc_waddr_o / vc_wdata_o = captured evict fields.
  - Go to RESP.
  - vc_we_o is 0 in every other state.
- RESP:
  - resp_valid_o=1; resp_data_o and resp_from_vc_o are held stable until resp_ready_i=1, then go to IDLE.
  - A new request can be accepted the cycle after the RESP handshake.
- Latency: on a victim-cache hit, request accepted at edge T gives resp_valid_o high in cycle T+3. On a miss, resp_valid_o is high 2 cycles after mem_resp_valid_i.
- Flush:
  - vc_flush_o = flush_i, combinationally, in every state.
  - In IDLE, LOOKUP, EVICT or RESP: abort to IDLE next cycle. The pending response is dropped, no vc write occurs, and counters are kept (a LOOKUP-cycle increment still counts).
  - In MEM_REQ or MEM_WAIT: set sticky abort_q. The memory transaction completes normally; on mem_resp_valid_i, go to IDLE (skip EVICT/RESP) and clear abort_q.
  - flush_i has no effect on counters.
- Counters saturate at all-ones; they are cleared only by rst_ni.
- Reset asserted mid-operation: return immediately to reset values, including during a pending memory transaction. Any memory response arriving after reset is ignored in IDLE.
- Captured addresses are passed unmodified to the victim cache, which ignores offset bits. Only mem_req_addr_o is offset-zeroed (low log2(LINE_WIDTH/8) bits).

Test Plan:
- Reset release, then req addr 0x1000 with evict 0x2000/data A, vc_hit_i=1 with data B in LOOKUP -> vc_we_o at T+2 with waddr 0x2000/data A; resp_valid_o at T+3 with data B, resp_from_vc_o=1; hit_count=1.
- Req 0x1040, vc_hit_i=0, mem_req_ready_i low 3 cycles, response data C 5 cycles later -> mem_req_valid_o held 4 cycles with addr 0x1040; resp data C with resp_from_vc_o=0; miss_count=1.
- Miss with evict_valid_i=0 -> EVICT cycle has vc_we_o=0; response still delivered.
- Hold resp_ready_i low 4 cycles -> resp_valid_o/resp_data_o stable; req_ready_o=0 until the cycle after the handshake.
- flush_i pulsed in MEM_WAIT -> vc_flush_o=1 that cycle; after mem_resp_valid_i, no vc_we_o, no resp_valid_o; state IDLE, req_ready_o=1.
- rst_ni driven low asynchronously mid-MEM_REQ -> mem_req_valid_o, vc_en_o and counters go to 0 without waiting for a clock edge; no response after release.
